mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage access engine between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the load/store request from EX/MEM and runs a req/ready handshake with data memory. It aligns store data into byte lanes and sign- or zero-extends load data, then presents the result for MEM/WB to capture. While an access is outstanding it stalls the pipeline, and it raises misalign and bus-error flags.

Parameters:
TIMEOUT, 15, maximum cycles spent in BUSY waiting for dm_ready before a bus error is declared (1..255)
CNT_W, 8, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  pipeline clock; all state updates on the falling edge, the same edge as the pipeline registers
reset  in  1  asynchronous, active-low reset
mem_read  in  1  load request from EX/MEM
mem_write  in  1  store request from EX/MEM
mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  in  1  1 = zero-extend loads
addr  in  32  byte address (ALU result)
wdata  in  32  store data, right-justified
dm_req  out  1  memory request, held until accepted
dm_we  out  1  1 = write
dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dm_wdata  out  32  lane-replicated store data
dm_be  out  4  byte enables, bit0 = byte at offset 0 (little-endian)
dm_ready  in  1  memory accepted/completed the access this cycle
dm_rdata  in  32  read word, valid when dm_ready=1
load_data  out  32  formatted load result to MEM/WB DataMem input
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB keeps sampling
misalign  out  1  current op is misaligned and was suppressed
bus_err  out  1  last access timed out

Behaviour:
- Reset (reset=0, async): state=IDLE; dm_req, dm_we, dm_addr, dm_wdata, dm_be, load_data, bus_err, wait counter all 0; stall and misalign forced 0. Any access in flight is abandoned with no retry.
- op = mem_read | mem_write. If both are set, the op is a read.
- aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=00.
- misalign (combinational) = op & !aligned. The op is suppressed: no dm_req, stall=0, load_data driven 0 in the same cycle.
- FSM states: IDLE, BUSY, DONE.
- IDLE: stall = op & aligned (combinational). On the falling edge with op & aligned:
  - Latch dm_addr, dm_we=mem_write, dm_be, dm_wdata, size, unsigned and addr[1:0].
  - Set dm_req=1, clear bus_err and the counter, go to BUSY.
- BUSY: stall=1; dm_req and all dm_* outputs held stable. On each falling edge:
  - If dm_ready=1: dm_req<=0. For a read, load_data<=format(dm_rdata). Go to DONE.
  - Else if counter==TIMEOUT-1: dm_req<=0, bus_err<=1, load_data<=0, go to DONE.
  - Else counter+1.
- DONE: stall=0 for exactly one cycle, so EX/MEM advances and MEM/WB captures load_data on the same edge. Next edge: IDLE. No new op is accepted in DONE.
- Latency: with zero-wait memory (dm_ready high in the first BUSY cycle) an access is IDLE+BUSY+DONE = 3 cycles, stall high 2 cycles. Each wait cycle adds 1.
- Store lanes:
  - byte: dm_wdata={4{wdata[7:0]}}, dm_be=0001<<addr[1:0].
  - half: {2{wdata[15:0]}}, dm_be=0011<<addr[1:0].
  - word: wdata, dm_be=1111.
  - Reads: dm_be=1111.
- Load format: select byte lane addr[1:0] or half lane addr[1]; sign-extend unless mem_unsigned; word passes through.
- load_data holds its value until the next completed read, timeout (cleared to 0) or reset. Stores leave it unchanged.
- bus_err stays high until the next accepted op or reset.
- dm_ready in IDLE or DONE is ignored.

Decomposition:
- Shared package holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings;
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - BE_ALL=4'b1111.
- One combinational sub-module, load_formatter (dm_rdata, offset, size, unsigned -> load_data). It is reused by the bench as the reference model.

Test Plan:
- Word load, addr 0x100, dm_ready high first BUSY cycle, dm_rdata 0x8899AABB -> dm_addr 0x100, dm_be 1111; stall high 2 cycles; load_data 0x8899AABB in DONE.
- Signed byte load addr 0x101, rdata 0x8899AABB -> 0xFFFFFFAA. Repeat with mem_unsigned=1 -> 0x000000AA. Half load addr 0x102 signed -> 0xFFFF8899.
- Half store addr 0x102, wdata 0x0000BEEF, 3 wait cycles -> dm_addr 0x100, dm_wdata 0xBEEFBEEF, dm_be 1100, dm_we 1 held stable 4 BUSY cycles; stall 5 cycles; load_data unchanged.
- Word load addr 0x103 -> misalign=1, stall=0, dm_req never asserted, load_data 0.
- dm_ready held 0 -> bus_err=1 after exactly TIMEOUT BUSY cycles (15 with default); dm_req drops; DONE releases stall; next op clears bus_err.
- Reset asserted mid-BUSY -> dm_req, stall and all outputs 0 immediately (asynchronous); after release the FSM is in IDLE and the next op starts cleanly.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access engine.
// Holds the mem_size encodings, the access FSM state type and the
// all-lanes byte-enable constant used by the top and the load formatter.
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Load formatter: picks the addressed byte or halfword out of a read word
// and sign- or zero-extends it; word loads pass straight through.
// Ports:
//   rdata       - raw 32-bit word returned by data memory
//   offset      - byte offset of the access within the word (addr[1:0])
//   size        - access size (byte / half / word, 2'b11 behaves as word)
//   is_unsigned - 1 = zero-extend, 0 = sign-extend
//   data        - formatted, right-justified load result
module load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase

        // A halfword access is always halfword aligned, so only offset[1] matters.
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            SIZE_BYTE:        data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SIZE_HALF:        data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            SIZE_WORD, 2'b11: data = rdata;
            default:          data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access engine between EX/MEM and MEM/WB.
// Runs a req/ready handshake with data memory for aligned loads and stores,
// places store data on the right byte lanes, formats load data, stalls the
// pipeline while an access is outstanding and flags misaligned ops and
// memory timeouts. All state moves on the falling clock edge, like the
// pipeline registers around it.
// Ports:
//   clk, reset         - clock (falling edge active), async active-low reset
//   mem_read/mem_write - load / store request from EX/MEM (both set = load)
//   mem_size           - 00 byte, 01 half, 10/11 word
//   mem_unsigned       - zero-extend loads
//   addr, wdata        - byte address and right-justified store data
//   dm_*               - data-memory request channel and read data
//   load_data          - formatted load result for MEM/WB
//   stall              - freeze the front of the pipeline
//   misalign, bus_err  - suppressed misaligned op / last access timed out
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       size_q;
    logic [1:0]       offset_q;
    logic             unsigned_q;
    logic [31:0]      load_q;
    logic [31:0]      fmt_data;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_be;
    logic             op, is_store, aligned, accept, timeout_hit, stall_fsm;

    // A request with both read and write set is treated as a load.
    assign op       = mem_read | mem_write;
    assign is_store = mem_write & ~mem_read;

    // Alignment rule: bytes always, halves on even addresses, words on 4-byte boundaries.
    always_comb begin
        aligned = 1'b1;
        case (mem_size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~addr[0];
            default:   aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign accept      = op & aligned;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Flags are gated by reset so they read 0 while reset is held,
    // even though they are otherwise purely combinational on the inputs.
    assign misalign  = reset & op & ~aligned;
    assign stall     = reset & stall_fsm;
    assign load_data = misalign ? 32'd0 : load_q;

    // Store data is replicated across lanes so memory only needs the byte enables.
    always_comb begin
        lane_wdata = wdata;
        lane_be    = BE_ALL;
        if (is_store) begin
            case (mem_size)
                SIZE_BYTE: begin
                    lane_wdata = {4{wdata[7:0]}};
                    lane_be    = 4'b0001 << addr[1:0];
                end
                SIZE_HALF: begin
                    lane_wdata = {2{wdata[15:0]}};
                    lane_be    = 4'b0011 << addr[1:0];
                end
                default: begin
                    lane_wdata = wdata;
                    lane_be    = BE_ALL;
                end
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata       (dm_rdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (fmt_data)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE lasts exactly one cycle with stall low so EX/MEM advances and
    // MEM/WB captures load_data on the same edge; no op is accepted there.
    always_comb begin
        state_d   = state_q;
        stall_fsm = 1'b0;
        case (state_q)
            IDLE: begin
                stall_fsm = accept;
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_fsm = 1'b1;
                if (dm_ready || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter and result registers. The request fields
    // are captured once on acceptance and held stable for the whole of BUSY.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= 32'd0;
            dm_wdata   <= 32'd0;
            dm_be      <= 4'd0;
            size_q     <= 2'd0;
            offset_q   <= 2'd0;
            unsigned_q <= 1'b0;
            wait_cnt   <= '0;
            load_q     <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dm_req     <= 1'b1;
                        dm_we      <= is_store;
                        dm_addr    <= {addr[31:2], 2'b00};
                        dm_wdata   <= lane_wdata;
                        dm_be      <= lane_be;
                        size_q     <= mem_size;
                        offset_q   <= addr[1:0];
                        unsigned_q <= mem_unsigned;
                        wait_cnt   <= '0;
                        bus_err    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dm_ready) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            load_q <= fmt_data;
                        end
                    end else if (timeout_hit) begin
                        dm_req  <= 1'b0;
                        bus_err <= 1'b1;
                        load_q  <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. The driver issues directed and
// random ops, playing the memory side itself, and pushes the expected
// request and completion into queues computed from a small behavioural
// model. An independent monitor samples on the rising edge (the DUT moves
// on the falling edge) and pops/compares whenever the DUT raises a request,
// completes an access or flags a misaligned op.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        is_misalign;
        logic [31:0] load;
        logic        bus_err;
        logic [7:0]  stalls;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic [31:0] load_data;
    logic        stall, misalign, bus_err;

    int testsRun = 0;
    int failed   = 0;

    req_t  reqQ[$];
    resp_t respQ[$];

    logic [31:0] modelLoad;
    logic        modelBusErr;

    logic monPrevReq;
    int   monStallCnt;
    req_t monCur;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_be        (dm_be),
        .dm_ready     (dm_ready),
        .dm_rdata     (dm_rdata),
        .load_data    (load_data),
        .stall        (stall),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference load formatting written with plain integer arithmetic.
    function automatic logic [31:0] fmtRef(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
        int unsigned lane;
        int          v;
        if (sz == 2'b00) begin
            lane = (rd >> (8 * int'(off))) & 32'hFF;
            v    = (!uns && lane >= 128) ? int'(lane) - 256 : int'(lane);
            return 32'(v);
        end else if (sz == 2'b01) begin
            lane = (rd >> (16 * int'(off[1]))) & 32'hFFFF;
            v    = (!uns && lane >= 32768) ? int'(lane) - 65536 : int'(lane);
            return 32'(v);
        end
        return rd;
    endfunction

    task automatic clearOp();
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'($urandom_range(0, 3));
        mem_unsigned = 1'($urandom_range(0, 1));
        addr         = $urandom;
        wdata        = $urandom;
        dm_ready     = 1'b0;
    endtask

    // One pipeline op held on the EX/MEM inputs until it retires.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                 input int waits, input logic tmo, input logic [31:0] rdat);
        logic  op, ok;
        req_t  rq;
        resp_t rs;
        op = rd | wr;
        ok = (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz[1] && a[1:0] == 2'b00);
        @(negedge clk); #1;
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
        dm_ready     = 1'b0;
        if (!op) begin
            dm_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            clearOp();
            return;
        end
        if (!ok) begin
            rs.is_misalign = 1'b1;
            rs.load        = 32'd0;
            rs.bus_err     = modelBusErr;
            rs.stalls      = 8'd0;
            respQ.push_back(rs);
            @(negedge clk); #1;
            clearOp();
            return;
        end
        rq.addr = {a[31:2], 2'b00};
        rq.we   = wr & ~rd;
        rq.be   = 4'b1111;
        rq.wdata = wd;
        if (rq.we && sz == 2'b00) begin
            rq.be    = 4'b0001 << a[1:0];
            rq.wdata = {4{wd[7:0]}};
        end else if (rq.we && sz == 2'b01) begin
            rq.be    = 4'b0011 << a[1:0];
            rq.wdata = {2{wd[15:0]}};
        end
        reqQ.push_back(rq);
        if (tmo) begin
            modelLoad   = 32'd0;
            modelBusErr = 1'b1;
            rs.stalls   = 8'(TIMEOUT + 1);
        end else begin
            modelBusErr = 1'b0;
            if (!rq.we) modelLoad = fmtRef(rdat, a[1:0], sz, uns);
            rs.stalls = 8'(waits + 2);
        end
        rs.is_misalign = 1'b0;
        rs.load        = modelLoad;
        rs.bus_err     = modelBusErr;
        respQ.push_back(rs);
        @(negedge clk); #1;
        if (tmo) begin
            repeat (TIMEOUT) @(negedge clk);
        end else begin
            dm_rdata = $urandom;
            repeat (waits) @(negedge clk);
            #1;
            dm_ready = 1'b1;
            dm_rdata = rdat;
            @(negedge clk);
        end
        #1;
        dm_ready = 1'($urandom_range(0, 1));
        dm_rdata = $urandom;
        @(negedge clk); #1;
        clearOp();
    endtask

    // Monitor: pops expectations as the DUT presents requests and results.
    initial begin
        monPrevReq  = 1'b0;
        monStallCnt = 0;
        monCur      = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                monPrevReq  = 1'b0;
                monStallCnt = 0;
            end else begin
                if (stall) monStallCnt++;
                if (misalign) begin
                    if (respQ.size() == 0) begin
                        testsRun++; failed++;
                        $display("[TB] FAIL unexpected_misalign: got misalign=1, expected 0");
                    end else begin
                        resp_t rs;
                        rs = respQ.pop_front();
                        checkOutput("misalign_expected", 32'(rs.is_misalign), 32'd1);
                        checkOutput("misalign_stall", 32'(stall), 32'd0);
                        checkOutput("misalign_req", 32'(dm_req), 32'd0);
                        checkOutput("misalign_load", load_data, 32'd0);
                        checkOutput("misalign_bus_err", 32'(bus_err), 32'(rs.bus_err));
                    end
                end
                if (dm_req && !monPrevReq) begin
                    if (reqQ.size() == 0) begin
                        testsRun++; failed++;
                        $display("[TB] FAIL unexpected_req: got dm_req=1, expected no request");
                    end else begin
                        monCur = reqQ.pop_front();
                        checkOutput("req_addr", dm_addr, monCur.addr);
                        checkOutput("req_we", 32'(dm_we), 32'(monCur.we));
                        checkOutput("req_be", 32'(dm_be), 32'(monCur.be));
                        if (monCur.we) checkOutput("req_wdata", dm_wdata, monCur.wdata);
                    end
                end else if (dm_req && monPrevReq) begin
                    checkOutput("hold_addr", dm_addr, monCur.addr);
                    checkOutput("hold_we", 32'(dm_we), 32'(monCur.we));
                    checkOutput("hold_be", 32'(dm_be), 32'(monCur.be));
                    if (monCur.we) checkOutput("hold_wdata", dm_wdata, monCur.wdata);
                end
                if (!dm_req && monPrevReq) begin
                    if (respQ.size() == 0) begin
                        testsRun++; failed++;
                        $display("[TB] FAIL unexpected_done: got completion, expected none");
                    end else begin
                        resp_t rs;
                        rs = respQ.pop_front();
                        checkOutput("done_kind", 32'(rs.is_misalign), 32'd0);
                        checkOutput("done_load", load_data, rs.load);
                        checkOutput("done_bus_err", 32'(bus_err), 32'(rs.bus_err));
                        checkOutput("done_stall_cycles", 32'(monStallCnt), 32'(rs.stalls));
                    end
                    monStallCnt = 0;
                end
                monPrevReq = dm_req;
            end
        end
    end

    initial begin
        reset        = 1'b0;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        mem_size     = 2'b10;
        mem_unsigned = 1'b0;
        addr         = 32'h0000_0103;
        wdata        = 32'd0;
        dm_ready     = 1'b0;
        dm_rdata     = 32'd0;
        modelLoad    = 32'd0;
        modelBusErr  = 1'b0;
        #2;
        checkOutput("rst_dm_req", 32'(dm_req), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_misalign", 32'(misalign), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst_dm_addr", dm_addr, 32'd0);
        checkOutput("rst_dm_be", 32'(dm_be), 32'd0);
        clearOp();
        @(negedge clk); #1;
        reset = 1'b1;

        // Directed cases.
        applyStimulus(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'h8899AABB);
        applyStimulus(1, 0, 2'b00, 0, 32'h101, 32'h0, 0, 0, 32'h8899AABB);
        applyStimulus(1, 0, 2'b00, 1, 32'h101, 32'h0, 1, 0, 32'h8899AABB);
        applyStimulus(1, 0, 2'b01, 0, 32'h102, 32'h0, 0, 0, 32'h8899AABB);
        applyStimulus(0, 1, 2'b01, 0, 32'h102, 32'h0000BEEF, 3, 0, 32'h12345678);
        applyStimulus(1, 0, 2'b10, 0, 32'h103, 32'h0, 0, 0, 32'h0);
        applyStimulus(1, 0, 2'b10, 0, 32'h200, 32'h0, 0, 1, 32'h0);
        applyStimulus(0, 1, 2'b00, 0, 32'h201, 32'h0, 0, 1, 32'h0);
        applyStimulus(1, 0, 2'b01, 0, 32'h301, 32'h0, 0, 0, 32'h0);
        applyStimulus(1, 1, 2'b11, 1, 32'h204, 32'h55, 2, 0, 32'hCAFEF00D);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            int          r;
            logic        rd, wr, tmo;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            rd = (r >= 1 && r <= 5) || r == 9;
            wr = (r >= 6);
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            tmo = ($urandom_range(0, 24) == 0);
            applyStimulus(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
                          $urandom, $urandom_range(0, 4), tmo, $urandom);
        end

        // Reset in the middle of BUSY abandons the access.
        @(negedge clk); #1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        mem_size  = 2'b10;
        addr      = 32'h0000_0400;
        dm_ready  = 1'b0;
        reqQ.push_back('{addr: 32'h400, we: 1'b0, be: 4'b1111, wdata: 32'd0});
        @(negedge clk);
        @(negedge clk); #3;
        reset = 1'b0;
        reqQ.delete();
        respQ.delete();
        modelLoad   = 32'd0;
        modelBusErr = 1'b0;
        #1;
        checkOutput("midrst_dm_req", 32'(dm_req), 32'd0);
        checkOutput("midrst_stall", 32'(stall), 32'd0);
        checkOutput("midrst_dm_addr", dm_addr, 32'd0);
        checkOutput("midrst_dm_be", 32'(dm_be), 32'd0);
        checkOutput("midrst_dm_we", 32'(dm_we), 32'd0);
        checkOutput("midrst_load", load_data, 32'd0);
        checkOutput("midrst_bus_err", 32'(bus_err), 32'd0);
        clearOp();
        @(negedge clk); #1;
        reset = 1'b1;
        applyStimulus(1, 0, 2'b00, 0, 32'h403, 32'h0, 1, 0, 32'h80FF7F01);
        applyStimulus(0, 1, 2'b10, 0, 32'h404, 32'hA5A5_5A5A, 0, 0, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("req_queue_drained", 32'(reqQ.size()), 32'd0);
        checkOutput("resp_queue_drained", 32'(respQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failed);
        $finish;
    end

endmodule
